// File: rtl/h2v_list_pkg.sv
// Shared definitions for the list pipeline stages (enumerate, map, filter, fold).
package h2v_list_pkg;

  localparam int LIST_DATA_W = 8;
  localparam int LIST_ACC_W  = 16;
  localparam int LIST_CNT_W  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } list_state_t;

endpackage

// File: rtl/list_fold_acc.sv
// Registered fold accumulator: clear has priority over add.
// With LIST_FOLD_SAT_EN defined the add clamps at all-ones and flags a sticky ovf.
module list_fold_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] value,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

`ifdef LIST_FOLD_SAT_EN
  // One spare bit catches the carry that signals a clamp.
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc} + (ACC_W+1)'(value);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      if (sum[ACC_W]) begin
        acc <= '1;
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end
`else
  logic [ACC_W-1:0] sum;
  assign sum = acc + ACC_W'(value);
  assign ovf = 1'b0;

  always_ff @(posedge clock) begin
    if (reset || clear)
      acc <= '0;
    else if (add_en)
      acc <= sum;
  end
`endif

endmodule

// File: rtl/list_fold_sum.sv
// Folds a bounded list from the enumerator into a sum and element count.
// Optional saturating add selected by LIST_FOLD_SAT_EN.
module list_fold_sum
  import h2v_list_pkg::*;
#(
  parameter int DATA_W = LIST_DATA_W,
  parameter int ACC_W  = LIST_ACC_W,
  parameter int CNT_W  = LIST_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              up_ready,
  output logic              up_req,
  input  logic              up_ack,
  input  logic              up_eol,
  input  logic [DATA_W-1:0] up_value
);

  list_state_t      state, state_nxt;
  logic             up_ready_nxt, up_req_nxt, done_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             clr, add_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      up_ready <= 1'b0;
      up_req   <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      up_ready <= up_ready_nxt;
      up_req   <= up_req_nxt;
      done     <= done_nxt;
      count    <= count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    up_ready_nxt = up_ready;
    up_req_nxt   = up_req;
    done_nxt     = done;
    count_nxt    = count;
    clr          = 1'b0;
    add_en       = 1'b0;
    case (state)
      IDLE: begin
        clr          = 1'b1;
        count_nxt    = '0;
        up_ready_nxt = 1'b0;
        up_req_nxt   = 1'b0;
        done_nxt     = 1'b0;
        if (ready) begin
          state_nxt    = RUN;
          up_ready_nxt = 1'b1;
          up_req_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (!ready) begin
          state_nxt    = IDLE;
          clr          = 1'b1;
          count_nxt    = '0;
          up_ready_nxt = 1'b0;
          up_req_nxt   = 1'b0;
          done_nxt     = 1'b0;
        end else if (up_ack) begin
          add_en    = 1'b1;
          count_nxt = count + CNT_W'(1);
          // The eol element is folded in the same cycle it ends the list.
          if (up_eol) begin
            state_nxt  = DONE;
            up_req_nxt = 1'b0;
            done_nxt   = 1'b1;
          end
        end
      end
      DONE: begin
        // up_ready stays high so the enumerator holds; its trailing ack is ignored.
        if (!ready) begin
          state_nxt    = IDLE;
          clr          = 1'b1;
          count_nxt    = '0;
          up_ready_nxt = 1'b0;
          up_req_nxt   = 1'b0;
          done_nxt     = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  list_fold_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clock  (clock),
    .reset  (reset),
    .clear  (clr),
    .add_en (add_en),
    .value  (up_value),
    .acc    (result),
    .ovf    (ovf)
  );

endmodule

// File: doc/list_fold_sum.md
# list_fold_sum

Downstream consumer for the `BoundedEnum` list producer. It pulls every element of a bounded list over the req/ack/eol handshake and folds the elements into a running sum and element count. It presents the result to its parent through a level `ready` / registered `done` pair. It is the hardware form of `foldl (+) 0 [min..max]` and sits between the enumerator and the expression that consumes the fold result.

## Interface
Parameters:
- `DATA_W`, 8: element width. Must match the enumerator's `value` width.
- `ACC_W`, 16: accumulator width. Must satisfy ACC_W ≥ DATA_W.
- `CNT_W`, 9: count width. It holds 0..256 elements.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ready`  in  1  parent level request. Held high for the whole evaluation; lowering it aborts or releases.
- `done`  out  1  result valid. Held until `ready` falls.
- `result`  out  ACC_W  sum of elements.
- `count`  out  CNT_W  number of elements folded.
- `ovf`  out  1  sticky overflow; see Configuration.
- `up_ready`  out  1  drives the enumerator's `ready`.
- `up_req`  out  1  drives the enumerator's `req`.
- `up_ack`  in  1  enumerator `ack`. Registered and arrives one cycle after `req`.
- `up_eol`  in  1  enumerator `eol`. Combinational and meaningful only while `up_ack`=1.
- `up_value`  in  DATA_W  enumerator `value`.

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - acc=0, count=0, up_ready=0, up_req=0, done=0, ovf=0.
  - On `ready`=1, go to RUN and set up_ready=1, up_req=1.
- RUN, each cycle with up_ack=1:
  - acc += zero-extended up_value; count += 1.
  - If up_eol=1 in that same cycle: the element is included, then up_req←0, done←1, go to DONE.
- RUN with up_ack=0: hold all state.
- DONE:
  - up_ready stays 1 so the enumerator does not reload.
  - up_ack is ignored. The enumerator emits one stale ack after eol, and that ack must not be counted.
- Leaving DONE: when `ready`=0, go to IDLE. up_ready falls, so the enumerator reloads `min` on the next request.
- `ready`=0 in RUN: abort to IDLE and clear everything. done never asserts.
- `reset` in any state: IDLE with all outputs 0. This takes priority over every other event.
- `result`=acc and `count`=count are visible in every state; only `done` qualifies them.
- Arithmetic:
  - Addition is unsigned at ACC_W.
  - Wrap-around versus saturation is selected by the macro below.
  - count never overflows, since at most 2^DATA_W elements are possible.
- Degenerate list (min > max): the enumerator yields `min` with eol=1. The result is the single element: count=1, result=min.

## Timing
- E0 is the edge sampling `ready`=1 in IDLE.
- E1: the enumerator loads `min`; up_ack=1 from E1.
- E2..E(N+1): one element is folded per edge.
- `done`=1 is visible after E(N+1). Latency is N+1 cycles for N elements.
- Throughput is one element per cycle; up_req is held continuously in RUN.
- A `ready` fall is seen at the next edge; done, up_ready and up_req are low one cycle later.
- A new evaluation needs `ready` low for at least one cycle.

## Configuration
- `LIST_FOLD_SAT_EN` defined:
  - The add saturates at 2^ACC_W−1.
  - `ovf` is set sticky on the first clamp and cleared only in IDLE or on reset.
  - count still increments normally.
- Undefined:
  - The add wraps modulo 2^ACC_W.
  - `ovf` is tied to 0.

## Structure
- Shared package `h2v_list_pkg`:
  - default DATA_W, ACC_W and CNT_W constants;
  - FSM state typedef (IDLE, RUN, DONE);
  - shared with the other list stages (map, filter).
- Sub-module `list_fold_acc`: registered accumulator with a clear input, an add-enable input, the saturation logic under `LIST_FOLD_SAT_EN`, and the `ovf` output.
- The top level holds the FSM and the handshake glue.

## Test plan
- Basic fold, enumerator min=3, max=6, `ready` held → done after E5, result=18, count=4, ovf=0. The stale post-eol ack is not counted.
- Single element, min=7, max=7 → done after E2, result=7, count=1. Degenerate min=9, max=2 → result=9, count=1.
- Full range, min=0, max=255, ACC_W=16 → result=32640, count=256. With ACC_W=8: result=128 wrapped without the macro; result=255 and ovf=1 with `LIST_FOLD_SAT_EN`.
- Abort: `ready` dropped after 2 elements (min=1, max=10) → IDLE next cycle, done stays 0, up_ready=0. Re-raising `ready` gives result=55, count=10.
- Reset mid-RUN: reset after 3 elements → all outputs 0 on the next edge. A subsequent run with min=3, max=6 gives result=18.
- Back-to-back runs: `ready` low for exactly 1 cycle between two runs → the second run restarts from min and gives an identical result and count.
